uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter between NUM_REQ byte-stream requesters. Each requester sends a packet, a run of bytes ending with req_last. Packets are granted round-robin and are never interleaved. The block drives TxData/XMitGo into the transmitter, paces bytes from TxEmpty, and inserts a programmable idle gap between packets.

---
 rtl/uart_arb_pkg.sv | 17 +
 rtl/uart_tx_arbiter_rr_arbiter.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared definitions for the UART transmit arbiter.
//   arb_state_t  - FSM state encoding, also exported on OutState for debug
//   grant_width  - width of a requester index for a given requester count
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2,
        GAP  = 2'd3
    } arb_state_t;

    function automatic int unsigned grant_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req       - request vector, one bit per requester
//   ptr       - highest-priority index; search runs upward from here and wraps
//   winner    - first requesting index at or after ptr (0 when none)
//   any_valid - at least one request is present
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned GW     = grant_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      ptr,
    output logic [GW-1:0]      winner,
    output logic               any_valid
);

    logic [GW-1:0] idx;

    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = GW'((32'(ptr) + k) % NUM_REQ);
            if (!any_valid && req[idx]) begin
                any_valid = 1'b1;
                winner    = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NUM_REQ byte-stream
// requesters. Whole packets (terminated by req_last) are granted round-robin
// and never interleaved; bytes are paced by TxEmpty with a guard window after
// each XMitGo, and an idle gap is inserted after every packet.
//   clk, rst   - clock, synchronous active-high reset
//   req_valid  - per-requester byte valid
//   req_data   - per-requester byte, requester i on [8i+7:8i]
//   req_last   - final byte of a packet (qualified by valid & ready)
//   req_ready  - byte accepted this cycle (one-hot or zero)
//   TxEmpty    - transmitter can take a byte
//   TxData     - registered byte to the transmitter
//   XMitGo     - registered one-cycle start pulse
//   grant_id   - current or most recent owner
//   busy       - high from grant until the end of the gap
//   OutState   - FSM state for debug
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned GUARD_CYCLES = 2,
    parameter int unsigned GAP_CYCLES   = 16,
    parameter int unsigned GAP_W        = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [8*NUM_REQ-1:0]               req_data,
    input  logic [NUM_REQ-1:0]                 req_last,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic                               TxEmpty,
    output logic [7:0]                         TxData,
    output logic                               XMitGo,
    output logic [grant_width(NUM_REQ)-1:0]    grant_id,
    output logic                               busy,
    output logic [1:0]                         OutState
);

    localparam int unsigned GW  = grant_width(NUM_REQ);
    localparam int unsigned GUW = $clog2(GUARD_CYCLES + 1);

    arb_state_t        state, state_nxt;
    logic [GW-1:0]     rr_ptr;
    logic [GW-1:0]     winner;
    logic              any_valid;
    logic [GUW-1:0]    guard_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              last_q;
    logic [7:0]        req_bytes [NUM_REQ];
    logic              accept;
    logic              guard_done;
    logic              gap_done;
    logic [GW-1:0]     ptr_after;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_bytes[g] = req_data[8*g +: 8];
    end

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    assign accept     = (state == SEND) && req_valid[grant_id] && TxEmpty;
    // Counters are loaded with the full duration and expire on their last
    // cycle, so HOLD lasts GUARD_CYCLES cycles and GAP lasts GAP_CYCLES.
    assign guard_done = (guard_cnt <= GUW'(1));
    assign gap_done   = (gap_cnt <= GAP_W'(1));
    assign ptr_after  = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + GW'(1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (any_valid) state_nxt = SEND;
            SEND: if (accept)    state_nxt = HOLD;
            HOLD: begin
                if (guard_done) begin
                    if (!last_q)              state_nxt = SEND;
                    else if (GAP_CYCLES == 0) state_nxt = IDLE;
                    else                      state_nxt = GAP;
                end
            end
            GAP:  if (gap_done)  state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        req_ready = '0;
        if (state == SEND) begin
            req_ready[grant_id] = req_valid[grant_id] & TxEmpty;
        end
        OutState = state;
    end

    // Datapath, counters and grant bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            TxData    <= '0;
            XMitGo    <= 1'b0;
            grant_id  <= '0;
            busy      <= 1'b0;
            rr_ptr    <= '0;
            guard_cnt <= '0;
            gap_cnt   <= '0;
            last_q    <= 1'b0;
        end else begin
            XMitGo <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant_id <= winner;
                        busy     <= 1'b1;
                    end
                end
                SEND: begin
                    if (accept) begin
                        TxData    <= req_bytes[grant_id];
                        XMitGo    <= 1'b1;
                        last_q    <= req_last[grant_id];
                        guard_cnt <= GUW'(GUARD_CYCLES);
                    end
                end
                HOLD: begin
                    if (guard_done) begin
                        if (last_q) begin
                            rr_ptr <= ptr_after;
                            if (GAP_CYCLES == 0) begin
                                busy <= 1'b0;
                            end else begin
                                gap_cnt <= GAP_W'(GAP_CYCLES);
                            end
                        end
                    end else begin
                        guard_cnt <= guard_cnt - GUW'(1);
                    end
                end
                GAP: begin
                    if (gap_done) begin
                        busy <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: drives packet sources into uart_tx_arbiter and checks
// every output each cycle against a timestamp-based model of the arbiter,
// plus literal expectations for the directed scenarios.
module tb_uart_tx_arbiter;

    localparam int NR   = 4;
    localparam int G    = 2;
    localparam int GAPC = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic            TxEmpty;
    logic [7:0]      TxData;
    logic            XMitGo;
    logic [1:0]      grant_id;
    logic            busy;
    logic [1:0]      OutState;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ      (NR),
        .GUARD_CYCLES (G),
        .GAP_CYCLES   (GAPC),
        .GAP_W        (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .TxEmpty   (TxEmpty),
        .TxData    (TxData),
        .XMitGo    (XMitGo),
        .grant_id  (grant_id),
        .busy      (busy),
        .OutState  (OutState)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Stimulus controls and per-requester packet sources
    bit          en [NR];
    bit          tx_drv;
    bit          rst_drv;
    byte unsigned q_data [NR][$];
    bit           q_last [NR][$];

    // Model: timestamps in units of clock edges
    int          ec = 0;            // index of the upcoming edge
    bit          m_known = 1'b0;
    bit          m_in_pkt;
    int          m_g, m_ptr, m_earliest, m_last_edge;
    bit          m_go;
    byte unsigned m_txd;

    // Observations of the DUT for the directed scenarios
    byte unsigned log_data [$];
    int           log_gid  [$];
    int           log_ec   [$];
    int           gap_seen, pulse_seen, gid_off0;
    int           rdy_seen [NR];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, ec);
    endtask

    // Phase implied by the timestamps: 0 idle, 1 send, 2 hold, 3 gap
    function automatic int m_phase();
        if (m_in_pkt) return (ec >= m_earliest) ? 1 : 2;
        if (ec <= m_last_edge + G) return 2;
        if (ec <= m_last_edge + G + GAPC) return 3;
        return 0;
    endfunction

    function automatic bit pending();
        for (int i = 0; i < NR; i++) if (q_data[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_in_pkt = 1'b0; m_g = 0; m_ptr = 0; m_earliest = 0;
        m_last_edge = -1000; m_go = 1'b0; m_txd = 8'h00;
    endtask

    task automatic clear_obs();
        log_data.delete(); log_gid.delete(); log_ec.delete();
        gap_seen = 0; pulse_seen = 0; gid_off0 = 0;
        for (int i = 0; i < NR; i++) rdy_seen[i] = 0;
    endtask

    task automatic push(input int r, input byte unsigned d, input bit l);
        q_data[r].push_back(d);
        q_last[r].push_back(l);
    endtask

    task automatic flush_sources();
        for (int i = 0; i < NR; i++) begin
            q_data[i].delete();
            q_last[i].delete();
        end
    endtask

    // One clock cycle: drive at the falling edge, check, advance the model
    task automatic tick();
        logic [NR-1:0] v;
        logic [NR-1:0] rdy;
        int            ph;
        bit            found;
        int            idx;
        for (int i = 0; i < NR; i++) begin
            v[i] = en[i] && (q_data[i].size() > 0);
            req_data[8*i +: 8] = v[i] ? q_data[i][0] : 8'($urandom);
            req_last[i]        = v[i] ? q_last[i][0] : 1'($urandom);
        end
        req_valid = v;
        TxEmpty   = tx_drv;
        rst       = rst_drv;
        #1;
        ph  = m_phase();
        rdy = '0;
        if (m_in_pkt && ph == 1) rdy[m_g] = v[m_g] & tx_drv;
        if (m_known) begin
            check("req_ready", 32'(req_ready), 32'(rdy));
            check("OutState",  32'(OutState),  32'(ph));
            check("busy",      32'(busy),      32'(m_in_pkt || (ec <= m_last_edge + G + GAPC)));
            check("grant_id",  32'(grant_id),  32'(m_g));
            check("XMitGo",    32'(XMitGo),    32'(m_go));
            check("TxData",    32'(TxData),    32'(m_txd));
        end
        if (XMitGo === 1'b1) begin
            log_data.push_back(TxData);
            log_gid.push_back(int'(grant_id));
            log_ec.push_back(ec);
            pulse_seen++;
        end
        if (OutState === 2'd3) gap_seen++;
        if (grant_id !== 2'd0) gid_off0++;
        for (int i = 0; i < NR; i++) if (req_ready[i] === 1'b1) rdy_seen[i]++;

        if (rst_drv) begin
            model_reset();
            m_known = 1'b1;
        end else begin
            m_go = 1'b0;
            if (ph == 0) begin
                found = 1'b0;
                for (int k = 0; k < NR; k++) begin
                    idx = (m_ptr + k) % NR;
                    if (!found && v[idx]) begin
                        found = 1'b1; m_g = idx; m_in_pkt = 1'b1; m_earliest = ec + 1;
                    end
                end
            end else if (ph == 1 && rdy[m_g]) begin
                m_txd = q_data[m_g][0];
                m_go  = 1'b1;
                m_earliest = ec + 1 + G;
                if (q_last[m_g][0]) begin
                    m_in_pkt = 1'b0;
                    m_ptr = (m_g + 1) % NR;
                    m_last_edge = ec;
                end
                void'(q_data[m_g].pop_front());
                void'(q_last[m_g].pop_front());
            end
        end
        ec++;
        @(negedge clk);
    endtask

    task automatic drain();
        int b = 0;
        for (int i = 0; i < NR; i++) en[i] = 1'b1;
        tx_drv = 1'b1;
        while ((m_phase() != 0 || m_in_pkt || pending()) && b < 3000) begin
            tick();
            b++;
        end
        check("drain_bound", 32'(b < 3000), 32'd1);
    endtask

    task automatic tick_until_pulses(input int n);
        int b = 0;
        while (pulse_seen < n && b < 500) begin
            tick();
            b++;
        end
        check("pulse_wait_bound", 32'(pulse_seen >= n), 32'd1);
    endtask

    task automatic check_log(input string name, input byte unsigned e[$]);
        check({name, "_len"}, 32'(log_data.size()), 32'(e.size()));
        for (int i = 0; i < e.size() && i < log_data.size(); i++)
            check({name, "_byte"}, 32'(log_data[i]), 32'(e[i]));
    endtask

    initial begin
        byte unsigned e[$];
        model_reset();
        for (int i = 0; i < NR; i++) en[i] = 1'b1;
        tx_drv  = 1'b1;
        rst_drv = 1'b1;
        rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; TxEmpty = 1'b1;
        @(negedge clk);
        repeat (3) tick();
        rst_drv = 1'b0;

        // Reset state
        check("rst_TxData",   32'(TxData),    32'h00);
        check("rst_XMitGo",   32'(XMitGo),    32'd0);
        check("rst_busy",     32'(busy),      32'd0);
        check("rst_OutState", 32'(OutState),  32'd0);
        check("rst_grant",    32'(grant_id),  32'd0);
        check("rst_ready",    32'(req_ready), 32'd0);

        // Three-byte packet from requester 0
        clear_obs();
        push(0, 8'h48, 1'b0); push(0, 8'h69, 1'b0); push(0, 8'h21, 1'b1);
        drain();
        e = '{8'h48, 8'h69, 8'h21};
        check_log("s1", e);
        check("s1_spacing_a", 32'(log_ec[1] - log_ec[0]), 32'd3);
        check("s1_spacing_b", 32'(log_ec[2] - log_ec[1]), 32'd3);
        check("s1_gap_cycles", 32'(gap_seen), 32'd16);

        // Requesters 1 and 2 contend straight out of reset
        rst_drv = 1'b1; flush_sources(); repeat (2) tick(); rst_drv = 1'b0;
        clear_obs();
        push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b1);
        push(2, 8'h21, 1'b0); push(2, 8'h22, 1'b1);
        drain();
        e = '{8'h11, 8'h12, 8'h21, 8'h22};
        check_log("s2", e);
        check("s2_gid0", 32'(log_gid[0]), 32'd1);
        check("s2_gid3", 32'(log_gid[3]), 32'd2);

        // Pointer wraps from 3 back to 0
        push(3, 8'h31, 1'b1);
        drain();
        clear_obs();
        push(0, 8'hA0, 1'b1); push(3, 8'hB0, 1'b1);
        drain();
        e = '{8'hA0, 8'hB0};
        check_log("s3", e);

        // TxEmpty held low for 40 cycles after a pulse
        clear_obs();
        push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b0); push(0, 8'h03, 1'b1);
        tick_until_pulses(1);
        tx_drv = 1'b0;
        pulse_seen = 0; rdy_seen[0] = 0;
        repeat (40) tick();
        check("s4_no_pulse", 32'(pulse_seen), 32'd0);
        check("s4_no_ready", 32'(rdy_seen[0]), 32'd0);
        tx_drv = 1'b1;
        tick();
        check("s4_accept_now", 32'(rdy_seen[0]), 32'd1);
        tick();
        check("s4_pulse_next", 32'(pulse_seen), 32'd1);
        drain();

        // Requester 0 stalls mid-packet while requester 1 waits
        clear_obs();
        en[1] = 1'b0;
        push(0, 8'h51, 1'b0); push(0, 8'h52, 1'b0); push(0, 8'h53, 1'b1);
        push(1, 8'h61, 1'b1);
        tick_until_pulses(1);
        en[0] = 1'b0; en[1] = 1'b1;
        rdy_seen[1] = 0; gid_off0 = 0;
        repeat (10) tick();
        check("s5_no_ready1", 32'(rdy_seen[1]), 32'd0);
        check("s5_grant_held", 32'(gid_off0), 32'd0);
        drain();
        e = '{8'h51, 8'h52, 8'h53, 8'h61};
        check_log("s5", e);

        // Reset during HOLD of byte 2 of 4
        clear_obs();
        push(2, 8'hC1, 1'b0); push(2, 8'hC2, 1'b0); push(2, 8'hC3, 1'b0); push(2, 8'hC4, 1'b1);
        tick_until_pulses(2);
        rst_drv = 1'b1; flush_sources();
        tick();
        rst_drv = 1'b0;
        check("s6_XMitGo",   32'(XMitGo),   32'd0);
        check("s6_OutState", 32'(OutState), 32'd0);
        check("s6_busy",     32'(busy),     32'd0);
        check("s6_TxData",   32'(TxData),   32'h00);
        clear_obs();
        push(1, 8'h71, 1'b1); push(3, 8'h72, 1'b1);
        drain();
        e = '{8'h71, 8'h72};
        check_log("s6", e);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int r = 0; r < NR; r++) begin
                en[r] = ($urandom_range(0, 99) < 85);
                if (q_data[r].size() == 0 && $urandom_range(0, 7) == 0) begin
                    int len;
                    len = $urandom_range(1, 5);
                    for (int j = 0; j < len; j++) push(r, 8'($urandom), j == len - 1);
                end
            end
            tx_drv  = ($urandom_range(0, 99) < 75);
            rst_drv = ($urandom_range(0, 599) == 0);
            if (rst_drv) flush_sources();
            tick();
            rst_drv = 1'b0;
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
